// File: rtl/pinball_pkg.sv
// Shared types and constants for the pinball game-state logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pinball_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        PLAY,
        BALL_LOST,
        GAME_OVER
    } game_state_t;

    localparam int SCORE_W = 14;
    localparam int LIVES_W = 3;

    localparam int GOOD_POINTS_DEF   = 10;
    localparam int BAD_POINTS_DEF    = 5;
    localparam int BUMPER_POINTS_DEF = 2;
    localparam int SCORE_MAX_DEF     = 9999;
    localparam int LIVES_INIT_DEF    = 3;
    localparam int LOST_FRAMES_DEF   = 60;

    // Clamp a signed working score into the displayable range 0..max_val.
    function automatic logic [SCORE_W-1:0] sat_score(
        input logic signed [15:0] value,
        input logic signed [15:0] max_val
    );
        logic [SCORE_W-1:0] result;
        if (value < 16'sd0) begin
            result = '0;
        end else if (value > max_val) begin
            result = max_val[SCORE_W-1:0];
        end else begin
            result = value[SCORE_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Sticky per-frame event flag: remembers any pulse seen since the last frame strobe.
// Latency: flag rises the cycle after the pulse; a pulse on the strobe cycle lands in the new frame.
// Backpressure: none; the flag is read by the consumer during the strobe cycle.
module frame_event_latch (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic event_pulse,
    output logic flag
);

    // On the strobe the old frame's value is consumed downstream, so reload with
    // only the current-cycle event; otherwise accumulate.
    always_ff @(posedge clk) begin
        if (resetN) begin
            flag <= 1'b0;
        end else if (startOfFrame) begin
            flag <= event_pulse;
        end else begin
            flag <= flag | event_pulse;
        end
    end

endmodule

// File: rtl/score_lives_controller.sv
// Turns collision events into score, lives, ball respawn and game-over state, applied once per frame.
// Latency: score/lives/state update the cycle after startOfFrame; ballRespawn is a registered 1-cycle pulse.
// Backpressure: none; every input is sampled every cycle and never stalled.
module score_lives_controller
    import pinball_pkg::*;
#(
    parameter int GOOD_POINTS   = GOOD_POINTS_DEF,
    parameter int BAD_POINTS    = BAD_POINTS_DEF,
    parameter int BUMPER_POINTS = BUMPER_POINTS_DEF,
    parameter int SCORE_MAX     = SCORE_MAX_DEF,
    parameter int LIVES_INIT    = LIVES_INIT_DEF,
    parameter int LOST_FRAMES   = LOST_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               startGame,
    input  logic               collisionBallObstacleGood,
    input  logic               collisionBallObstacleBad,
    input  logic               collisionBallBumper,
    input  logic               collisionBallBottom,
    input  logic               collisionBallSpringPulse,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               ballRespawn,
    output logic               gameActive,
    output logic               gameOver
);

    localparam int CNT_W = (LOST_FRAMES > 2) ? $clog2(LOST_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_FRAMES - 1);

    game_state_t        state;
    logic [CNT_W-1:0]   lost_cnt;
    logic               flag_good;
    logic               flag_bad;
    logic               flag_bumper;
    logic               flag_bottom;
    logic signed [15:0] score_sum;
    logic [SCORE_W-1:0] score_next;

    frame_event_latch u_good (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .event_pulse  (collisionBallObstacleGood),
        .flag         (flag_good)
    );

    frame_event_latch u_bad (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .event_pulse  (collisionBallObstacleBad),
        .flag         (flag_bad)
    );

    frame_event_latch u_bumper (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .event_pulse  (collisionBallBumper),
        .flag         (flag_bumper)
    );

    frame_event_latch u_bottom (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .event_pulse  (collisionBallBottom),
        .flag         (flag_bottom)
    );

    // Frame score delta in signed 16-bit so a penalty can go below zero before clamping.
    always_comb begin
        score_sum = signed'(16'(score));
        if (flag_good) begin
            score_sum = score_sum + 16'(GOOD_POINTS);
        end
        if (flag_bumper) begin
            score_sum = score_sum + 16'(BUMPER_POINTS);
        end
        if (flag_bad) begin
            score_sum = score_sum - 16'(BAD_POINTS);
        end
        score_next = sat_score(score_sum, 16'(SCORE_MAX));
    end

    // Game FSM with registered score, lives and status outputs.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state       <= IDLE;
            score       <= '0;
            lives       <= '0;
            lost_cnt    <= '0;
            ballRespawn <= 1'b0;
            gameActive  <= 1'b0;
            gameOver    <= 1'b0;
        end else begin
            ballRespawn <= 1'b0;
            case (state)
                IDLE, GAME_OVER: begin
                    if (startGame) begin
                        score       <= '0;
                        lives       <= LIVES_W'(LIVES_INIT);
                        ballRespawn <= 1'b1;
                        gameActive  <= 1'b1;
                        gameOver    <= 1'b0;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Ball rests on the spring; drain contact cannot happen here.
                    if (collisionBallSpringPulse) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (startOfFrame) begin
                        score <= score_next;
                        if (flag_bottom) begin
                            lives    <= lives - LIVES_W'(1);
                            lost_cnt <= '0;
                            state    <= BALL_LOST;
                        end
                    end
                end
                BALL_LOST: begin
                    if (startOfFrame) begin
                        if (lost_cnt == LOST_LAST) begin
                            if (lives != '0) begin
                                ballRespawn <= 1'b1;
                                state       <= LAUNCH;
                            end else begin
                                gameActive <= 1'b0;
                                gameOver   <= 1'b1;
                                state      <= GAME_OVER;
                            end
                        end else begin
                            lost_cnt <= lost_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_lives_controller.sv
// Self-checking bench for score_lives_controller: directed scenarios plus randomized run vs a reference model.
// Latency: model results are compared 1ns after each rising clock edge.
// Backpressure: n/a.
module tb_score_lives_controller;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        startGame = 1'b0;
    logic        collisionBallObstacleGood = 1'b0;
    logic        collisionBallObstacleBad = 1'b0;
    logic        collisionBallBumper = 1'b0;
    logic        collisionBallBottom = 1'b0;
    logic        collisionBallSpringPulse = 1'b0;
    logic [13:0] score;
    logic [2:0]  lives;
    logic        ballRespawn;
    logic        gameActive;
    logic        gameOver;

    int n_tests = 0;
    int n_fail  = 0;

    score_lives_controller dut (
        .clk                       (clk),
        .resetN                    (resetN),
        .startOfFrame              (startOfFrame),
        .startGame                 (startGame),
        .collisionBallObstacleGood (collisionBallObstacleGood),
        .collisionBallObstacleBad  (collisionBallObstacleBad),
        .collisionBallBumper       (collisionBallBumper),
        .collisionBallBottom       (collisionBallBottom),
        .collisionBallSpringPulse  (collisionBallSpringPulse),
        .score                     (score),
        .lives                     (lives),
        .ballRespawn               (ballRespawn),
        .gameActive                (gameActive),
        .gameOver                  (gameOver)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Game phases as plain integers; events are tracked as "seen during the current frame".
    localparam int M_IDLE = 0, M_LAUNCH = 1, M_PLAY = 2, M_LOST = 3, M_OVER = 4;
    int m_phase = M_IDLE;
    int m_score = 0;
    int m_lives = 0;
    int m_lost_sofs = 0;
    bit m_respawn = 0;
    bit m_seen_good = 0, m_seen_bad = 0, m_seen_bump = 0, m_seen_bot = 0;

    task automatic model_update(input bit r, input bit sof, input bit sg, input bit g,
                                input bit bd, input bit bu, input bit bot, input bit spr);
        bit cg, cb, cu, cbot;
        int s;
        if (r) begin
            m_phase = M_IDLE; m_score = 0; m_lives = 0; m_lost_sofs = 0; m_respawn = 0;
            m_seen_good = 0; m_seen_bad = 0; m_seen_bump = 0; m_seen_bot = 0;
            return;
        end
        m_respawn = 0;
        cg = m_seen_good; cb = m_seen_bad; cu = m_seen_bump; cbot = m_seen_bot;
        if (sof) begin
            m_seen_good = g; m_seen_bad = bd; m_seen_bump = bu; m_seen_bot = bot;
        end else begin
            m_seen_good |= g; m_seen_bad |= bd; m_seen_bump |= bu; m_seen_bot |= bot;
        end
        case (m_phase)
            M_IDLE, M_OVER: if (sg) begin
                m_score = 0; m_lives = 3; m_respawn = 1; m_phase = M_LAUNCH;
            end
            M_LAUNCH: if (spr) m_phase = M_PLAY;
            M_PLAY: if (sof) begin
                s = m_score + 10 * int'(cg) + 2 * int'(cu) - 5 * int'(cb);
                if (s < 0) s = 0;
                if (s > 9999) s = 9999;
                m_score = s;
                if (cbot) begin
                    m_lives = m_lives - 1; m_lost_sofs = 0; m_phase = M_LOST;
                end
            end
            M_LOST: if (sof) begin
                m_lost_sofs = m_lost_sofs + 1;
                if (m_lost_sofs == 60) begin
                    if (m_lives != 0) begin
                        m_respawn = 1; m_phase = M_LAUNCH;
                    end else begin
                        m_phase = M_OVER;
                    end
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    // One clock cycle: drive inputs, advance DUT and model, settle past the edge.
    task automatic step(input bit r, input bit sof, input bit sg, input bit g,
                        input bit bd, input bit bu, input bit bot, input bit spr);
        resetN = r; startOfFrame = sof; startGame = sg;
        collisionBallObstacleGood = g; collisionBallObstacleBad = bd;
        collisionBallBumper = bu; collisionBallBottom = bot; collisionBallSpringPulse = spr;
        @(posedge clk);
        model_update(r, sof, sg, g, bd, bu, bot, spr);
        #1;
    endtask

    // Events in one cycle, then a frame strobe that applies them.
    task automatic frame(input bit g, input bit bd, input bit bu, input bit bot);
        step(0, 0, 0, g, bd, bu, bot, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 1, 1);
        n_tests++;
        if ({score, lives, ballRespawn, gameActive, gameOver} !== {14'd0, 3'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset: score=%0d lives=%0d resp=%b act=%b over=%b, required 0 0 0 0 0",
                     score, lives, ballRespawn, gameActive, gameOver);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_start();
        step(0, 0, 1, 0, 0, 0, 0, 0);
        n_tests++;
        if ({lives, score, ballRespawn, gameActive, gameOver} !== {3'd3, 14'd0, 3'b110}) begin
            n_fail++;
            $display("FAIL start: lives=%0d score=%0d resp=%b act=%b over=%b, required 3 0 1 1 0",
                     lives, score, ballRespawn, gameActive, gameOver);
        end
        step(0, 0, 1, 0, 0, 0, 0, 0);
        n_tests++;
        if (ballRespawn !== 1'b0) begin
            n_fail++;
            $display("FAIL start_pulse_width: ballRespawn=%b, required 0", ballRespawn);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_scoring();
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (score !== 14'd12) begin
            n_fail++;
            $display("FAIL score_once_per_frame: score=%0d, required 12", score);
        end
    endtask

    task automatic test_saturation_low();
        frame(0, 1, 0, 0);
        frame(0, 1, 1, 0);
        frame(0, 0, 1, 0);
        frame(0, 1, 1, 0);
        n_tests++;
        if (score !== 14'd3) begin
            n_fail++;
            $display("FAIL score_reach_3: score=%0d, required 3", score);
        end
        frame(0, 1, 0, 0);
        n_tests++;
        if (score !== 14'd0) begin
            n_fail++;
            $display("FAIL sat_low: score=%0d, required 0", score);
        end
    endtask

    task automatic test_coincident();
        step(0, 1, 0, 1, 0, 0, 0, 0);
        n_tests++;
        if (score !== 14'd0) begin
            n_fail++;
            $display("FAIL coincident_same_frame: score=%0d, required 0", score);
        end
        step(0, 1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (score !== 14'd10) begin
            n_fail++;
            $display("FAIL coincident_next_frame: score=%0d, required 10", score);
        end
        step(0, 1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (score !== 14'd10) begin
            n_fail++;
            $display("FAIL coincident_no_double: score=%0d, required 10", score);
        end
    endtask

    task automatic test_saturation_high();
        for (int i = 0; i < 998; i++) frame(1, 0, 0, 0);
        frame(1, 1, 0, 0);
        n_tests++;
        if (score !== 14'd9995) begin
            n_fail++;
            $display("FAIL score_reach_9995: score=%0d, required 9995", score);
        end
        frame(1, 0, 0, 0);
        n_tests++;
        if (score !== 14'd9999) begin
            n_fail++;
            $display("FAIL sat_high: score=%0d, required 9999", score);
        end
        frame(1, 0, 1, 0);
        n_tests++;
        if (score !== 14'd9999) begin
            n_fail++;
            $display("FAIL sat_high_hold: score=%0d, required 9999", score);
        end
    endtask

    task automatic test_game_over();
        int resp_count;
        for (int ball = 0; ball < 3; ball++) begin
            frame(0, 0, 0, 1);
            n_tests++;
            if (lives !== 3'(2 - ball)) begin
                n_fail++;
                $display("FAIL drain_lives: lives=%0d, required %0d", lives, 2 - ball);
            end
            resp_count = 0;
            for (int f = 0; f < 60; f++) begin
                step(0, 1, 0, 0, 0, 0, 1, 0);
                if (ballRespawn === 1'b1) resp_count++;
            end
            n_tests++;
            if (resp_count != ((ball < 2) ? 1 : 0) || ballRespawn !== ((ball < 2) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL lost_respawn: respawn pulses=%0d last=%b, required %0d on frame 60",
                         resp_count, ballRespawn, (ball < 2) ? 1 : 0);
            end
            if (ball < 2) step(0, 0, 0, 0, 0, 0, 1, 1);
        end
        n_tests++;
        if ({gameOver, gameActive, lives} !== {1'b1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL game_over: over=%b act=%b lives=%0d, required 1 0 0", gameOver, gameActive, lives);
        end
        frame(0, 1, 0, 1);
        n_tests++;
        if (score !== 14'd9999 || lives !== 3'd0) begin
            n_fail++;
            $display("FAIL over_frozen: score=%0d lives=%0d, required 9999 0", score, lives);
        end
    endtask

    task automatic test_mid_reset();
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) frame(1, 0, 0, 0);
        n_tests++;
        if (score !== 14'd40) begin
            n_fail++;
            $display("FAIL mid_reset_setup: score=%0d, required 40", score);
        end
        step(0, 0, 0, 1, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        n_tests++;
        if ({score, lives, gameActive, gameOver, ballRespawn} !== {14'd0, 3'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_reset: score=%0d lives=%0d act=%b over=%b resp=%b, required 0 0 0 0 0",
                     score, lives, gameActive, gameOver, ballRespawn);
        end
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({score, lives, gameActive} !== {14'd0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset_frame: score=%0d lives=%0d act=%b, required 0 0 0", score, lives, gameActive);
        end
    endtask

    task automatic test_random();
        bit r, sof, sg, g, bd, bu, bot, spr;
        for (int i = 0; i < 6000; i++) begin
            r   = ($urandom_range(0, 999) == 0);
            sof = ($urandom_range(0, 2) == 0);
            sg  = ($urandom_range(0, 19) == 0);
            g   = ($urandom_range(0, 4) == 0);
            bd  = ($urandom_range(0, 5) == 0);
            bu  = ($urandom_range(0, 4) == 0);
            bot = ($urandom_range(0, 24) == 0);
            spr = ($urandom_range(0, 7) == 0);
            step(r, sof, sg, g, bd, bu, bot, spr);
            n_tests++;
            if (score !== 14'(m_score) || lives !== 3'(m_lives) || ballRespawn !== m_respawn ||
                gameActive !== (m_phase == M_LAUNCH || m_phase == M_PLAY || m_phase == M_LOST) ||
                gameOver !== (m_phase == M_OVER)) begin
                n_fail++;
                $display("FAIL random cycle %0d: score=%0d lives=%0d resp=%b act=%b over=%b, required %0d %0d %b %b %b",
                         i, score, lives, ballRespawn, gameActive, gameOver, m_score, m_lives, m_respawn,
                         (m_phase == M_LAUNCH || m_phase == M_PLAY || m_phase == M_LOST), (m_phase == M_OVER));
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_scoring();
        test_saturation_low();
        test_coincident();
        test_saturation_high();
        test_game_over();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
